// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the dual-port on-chip RAM: controller states,
// collision-winner encodings and the deepest supported read pipeline.
package onchip_mem_pkg;

  typedef logic state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_RUN   = 1'b1;

  localparam int COLL_A_WINS    = 0;
  localparam int COLL_B_WINS    = 1;
  localparam int MAX_RD_LATENCY = 2;

endpackage

// File: rtl/onchip_mem_rd_pipe.sv
// Per-port read return pipeline: one or two register stages carrying
// readdata and readdatavalid; data holds its last value while valid is low.
module onchip_mem_rd_pipe
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_vld_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_vld_o
);

  logic [DATA_W-1:0] data_p0_q;
  logic              vld_p0_q;

  // Stage 0: capture the array word at the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p0_q <= '0;
      vld_p0_q  <= 1'b0;
    end else begin
      vld_p0_q <= rd_vld_i;
      if (rd_vld_i) data_p0_q <= rd_data_i;
    end
  end

  generate
    if (RD_LATENCY < MAX_RD_LATENCY) begin : g_lat1
      assign rd_data_o = data_p0_q;
      assign rd_vld_o  = vld_p0_q;
    end else begin : g_lat2
      logic [DATA_W-1:0] data_p1_q;
      logic              vld_p1_q;

      // Stage 1: optional output register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_p1_q <= '0;
          vld_p1_q  <= 1'b0;
        end else begin
          vld_p1_q <= vld_p0_q;
          if (vld_p0_q) data_p1_q <= data_p0_q;
        end
      end

      assign rd_data_o = data_p1_q;
      assign rd_vld_o  = vld_p1_q;
    end
  endgenerate

endmodule

// File: rtl/avmm_dp_onchip_ram.sv
// True dual-port Avalon-MM on-chip RAM with post-reset zero-fill sweep,
// byte-lane writes and deterministic same-address write-write arbitration.
module avmm_dp_onchip_ram
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int COLLISION_MODE = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                freeze,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                a_chipselect,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic [DATA_W-1:0]   a_writedata,
  input  logic                a_clken,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  output logic                a_waitrequest,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_chipselect,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic [DATA_W-1:0]   b_writedata,
  input  logic                b_clken,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic                b_waitrequest,
  output logic                init_done,
  output logic                collision
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              coll_q, coll_d;

  logic              in_clear;
  logic              a_acc, b_acc;
  logic              a_wr_acc, b_wr_acc, a_rd_acc, b_rd_acc;
  logic              ww_coll;
  logic [BE_W-1:0]   a_be_eff, b_be_eff;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic [BE_W-1:0]   wa_be;

  assign in_clear      = (state_q == ST_CLEAR);
  assign init_done     = (state_q == ST_RUN);
  assign a_waitrequest = in_clear | freeze;
  assign b_waitrequest = in_clear | freeze;
  assign collision     = coll_q;

  assign a_acc    = a_chipselect & (a_read | a_write) & a_clken & ~a_waitrequest;
  assign b_acc    = b_chipselect & (b_read | b_write) & b_clken & ~b_waitrequest;
  assign a_wr_acc = a_acc & a_write;
  assign b_wr_acc = b_acc & b_write;
  assign a_rd_acc = a_acc & a_read & ~a_write;
  assign b_rd_acc = b_acc & b_read & ~b_write;
  assign ww_coll  = a_wr_acc & b_wr_acc & (a_address == b_address);

  // The loser of an equal-address write pair drops only the lanes it shares
  always_comb begin
    a_be_eff = a_wr_acc ? a_byteenable : '0;
    b_be_eff = b_wr_acc ? b_byteenable : '0;
    if (ww_coll) begin
      if (COLLISION_MODE == COLL_B_WINS) a_be_eff = a_be_eff & ~b_byteenable;
      else                               b_be_eff = b_be_eff & ~a_byteenable;
    end
  end

  // The clear sweep borrows port A's write path while both ports are stalled
  assign wa_addr = in_clear ? clr_cnt_q : a_address;
  assign wa_data = in_clear ? '0 : a_writedata;
  assign wa_be   = in_clear ? '1 : a_be_eff;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (wa_be[i])    mem_q[wa_addr][8*i +: 8]   <= wa_data[8*i +: 8];
      if (b_be_eff[i]) mem_q[b_address][8*i +: 8] <= b_writedata[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    coll_d    = ww_coll;
    if (in_clear) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      coll_q    <= coll_d;
    end
  end

  onchip_mem_rd_pipe #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe_a (
    .clk       (clk),
    .rst_n     (reset_n),
    .rd_vld_i  (a_rd_acc),
    .rd_data_i (mem_q[a_address]),
    .rd_data_o (a_readdata),
    .rd_vld_o  (a_readdatavalid)
  );

  onchip_mem_rd_pipe #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe_b (
    .clk       (clk),
    .rst_n     (reset_n),
    .rd_vld_i  (b_rd_acc),
    .rd_data_i (mem_q[b_address]),
    .rd_data_o (b_readdata),
    .rd_vld_o  (b_readdatavalid)
  );

endmodule

// File: tb/tb_avmm_dp_onchip_ram.sv
// Directed bench: two instances share stimulus; index 0 is RD_LATENCY=1 with
// port A winning collisions, index 1 is RD_LATENCY=2 with port B winning.
module tb_avmm_dp_onchip_ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        freeze;
  logic [3:0]  a_address, b_address;
  logic        a_chipselect, b_chipselect, a_read, b_read, a_write, b_write;
  logic [3:0]  a_byteenable, b_byteenable;
  logic [31:0] a_writedata, b_writedata;
  logic        a_clken, b_clken;

  logic [31:0] a_rd [2];
  logic [31:0] b_rd [2];
  logic        a_rv [2];
  logic        b_rv [2];
  logic        a_wr [2];
  logic        b_wr [2];
  logic        idone [2];
  logic        coll [2];

  int   n_vec = 0;
  int   n_err = 0;
  logic coll_seen;

  always #5 clk = ~clk;

  avmm_dp_onchip_ram #(.DATA_W(32), .ADDR_W(4), .RD_LATENCY(1),
                       .CLEAR_ON_RESET(1), .COLLISION_MODE(0)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read),
    .a_write(a_write), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_clken(a_clken), .a_readdata(a_rd[0]), .a_readdatavalid(a_rv[0]),
    .a_waitrequest(a_wr[0]),
    .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read),
    .b_write(b_write), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_clken(b_clken), .b_readdata(b_rd[0]), .b_readdatavalid(b_rv[0]),
    .b_waitrequest(b_wr[0]),
    .init_done(idone[0]), .collision(coll[0])
  );

  avmm_dp_onchip_ram #(.DATA_W(32), .ADDR_W(4), .RD_LATENCY(2),
                       .CLEAR_ON_RESET(1), .COLLISION_MODE(1)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read),
    .a_write(a_write), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
    .a_clken(a_clken), .a_readdata(a_rd[1]), .a_readdatavalid(a_rv[1]),
    .a_waitrequest(a_wr[1]),
    .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read),
    .b_write(b_write), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
    .b_clken(b_clken), .b_readdata(b_rd[1]), .b_readdatavalid(b_rv[1]),
    .b_waitrequest(b_wr[1]),
    .init_done(idone[1]), .collision(coll[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_chipselect = 0; a_read = 0; a_write = 0; a_byteenable = 0;
    b_chipselect = 0; b_read = 0; b_write = 0; b_byteenable = 0;
  endtask

  // Issue edge for whatever request is set up, then watch 4 cycles of returns
  task automatic collect(input int port, input logic [31:0] e0, input logic [31:0] e1,
                         input string tag);
    int          lat [2];
    logic [31:0] d [2];
    logic        v;
    logic [31:0] rdv;
    lat[0] = 0; lat[1] = 0; d[0] = '0; d[1] = '0;
    tick();
    idle();
    for (int n = 1; n <= 4; n++) begin
      for (int k = 0; k < 2; k++) begin
        v   = (port == 0) ? a_rv[k] : b_rv[k];
        rdv = (port == 0) ? a_rd[k] : b_rd[k];
        coll_seen = coll_seen | coll[k];
        if (v && lat[k] == 0) begin
          lat[k] = n;
          d[k]   = rdv;
        end
        if (n == 4) chk({tag, "_hold"}, rdv, (k == 0) ? e0 : e1);
      end
      if (n < 4) tick();
    end
    chk({tag, "_lat1"}, lat[0], 1);
    chk({tag, "_lat2"}, lat[1], 2);
    chk({tag, "_d1"}, d[0], e0);
    chk({tag, "_d2"}, d[1], e1);
  endtask

  task automatic rd(input int port, input logic [3:0] addr, input logic [31:0] e0,
                    input logic [31:0] e1, input string tag);
    if (port == 0) begin
      a_chipselect = 1; a_read = 1; a_address = addr;
    end else begin
      b_chipselect = 1; b_read = 1; b_address = addr;
    end
    collect(port, e0, e1, tag);
  endtask

  task automatic wr(input int port, input logic [3:0] addr, input logic [31:0] data,
                    input logic [3:0] be);
    if (port == 0) begin
      a_chipselect = 1; a_write = 1; a_address = addr; a_writedata = data; a_byteenable = be;
    end else begin
      b_chipselect = 1; b_write = 1; b_address = addr; b_writedata = data; b_byteenable = be;
    end
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, idx, fz;
    int rx [2];
    logic frz, vs;

    reset_n = 0; freeze = 0; a_clken = 1; b_clken = 1;
    a_address = 0; b_address = 0; a_writedata = 0; b_writedata = 0;
    idle();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_a_wait", a_wr[k], 1);
      chk("rst_b_wait", b_wr[k], 1);
      chk("rst_idone", idone[k], 0);
      chk("rst_rv", a_rv[k] | b_rv[k], 0);
      chk("rst_rd", a_rd[k] | b_rd[k], 0);
      chk("rst_coll", coll[k], 0);
    end

    // Clear sweep length and zero contents
    reset_n = 1;
    cnt = 0;
    while (a_wr[0] && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("clear_len", cnt, 16);
    for (int k = 0; k < 2; k++) begin
      chk("clear_idone", idone[k], 1);
      chk("clear_a_wait", a_wr[k], 0);
      chk("clear_b_wait", b_wr[k], 0);
    end
    for (int i = 0; i < 16; i++) rd(0, 4'(i), 32'h0, 32'h0, "clr_rd");

    // Byte-lane writes, no-op write, same-port read after write
    wr(0, 4'd5, 32'hDEADBEEF, 4'b1111);
    wr(0, 4'd5, 32'h000000AA, 4'b0001);
    rd(1, 4'd5, 32'hDEADBEAA, 32'hDEADBEAA, "be_rd");
    wr(0, 4'd5, 32'hFFFFFFFF, 4'b0000);
    rd(0, 4'd5, 32'hDEADBEAA, 32'hDEADBEAA, "be0_rd");
    wr(0, 4'd6, 32'hA5A5A5A5, 4'b1111);
    rd(0, 4'd6, 32'hA5A5A5A5, 32'hA5A5A5A5, "raw_rd");

    // Write-write collision with one overlapping lane
    a_chipselect = 1; a_write = 1; a_address = 4'd9; a_writedata = 32'h11111111; a_byteenable = 4'b0011;
    b_chipselect = 1; b_write = 1; b_address = 4'd9; b_writedata = 32'h22222222; b_byteenable = 4'b0110;
    tick();
    idle();
    for (int k = 0; k < 2; k++) chk("coll_pulse", coll[k], 1);
    tick();
    for (int k = 0; k < 2; k++) chk("coll_drop", coll[k], 0);
    rd(0, 4'd9, 32'h00221111, 32'h00222211, "coll_rd");

    // Write and read of the same word in one cycle
    wr(0, 4'd3, 32'hCAFEF00D, 4'b1111);
    coll_seen = 0;
    a_chipselect = 1; a_write = 1; a_address = 4'd3; a_writedata = 32'h12345678; a_byteenable = 4'b1111;
    b_chipselect = 1; b_read = 1; b_address = 4'd3;
    collect(1, 32'hCAFEF00D, 32'hCAFEF00D, "wr_rd_old");
    chk("wr_rd_nocoll", coll_seen, 0);
    rd(1, 4'd3, 32'h12345678, 32'h12345678, "wr_rd_new");

    // Back-to-back reads with a freeze after the fourth accept
    for (int i = 0; i < 8; i++) wr(0, 4'(i), 32'h100 + i, 4'b1111);
    idx = 0; fz = 0; rx[0] = 0; rx[1] = 0;
    for (int c = 0; c < 20; c++) begin
      frz = (idx == 4) && (fz < 3);
      freeze = frz;
      if (frz) fz++;
      a_chipselect = (idx < 8); a_read = (idx < 8); a_address = 4'(idx);
      #1;
      if (frz) for (int k = 0; k < 2; k++) chk("frz_wait", a_wr[k], 1);
      @(posedge clk);
      if (!frz && idx < 8) idx++;
      #1;
      for (int k = 0; k < 2; k++) begin
        if (a_rv[k]) begin
          chk("frz_data", a_rd[k], 32'h100 + rx[k]);
          rx[k]++;
        end
      end
      if (frz && fz == 3) for (int k = 0; k < 2; k++) chk("frz_cnt", rx[k], 4);
    end
    freeze = 0;
    idle();
    for (int k = 0; k < 2; k++) chk("frz_total", rx[k], 8);

    // Reset with reads in flight, then reset again mid-sweep
    a_chipselect = 1; a_read = 1; a_address = 4'd9;
    b_chipselect = 1; b_read = 1; b_address = 4'd9;
    @(posedge clk);
    #1;
    reset_n = 0;
    idle();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst2_rv", a_rv[k] | b_rv[k], 0);
      chk("rst2_rd", a_rd[k] | b_rd[k], 0);
      chk("rst2_wait", a_wr[k], 1);
      chk("rst2_idone", idone[k], 0);
    end
    tick();
    reset_n = 1;
    vs = 0;
    repeat (7) begin
      tick();
      for (int k = 0; k < 2; k++) vs = vs | a_rv[k] | b_rv[k];
    end
    reset_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_wait", a_wr[k], 1);
      chk("mid_idone", idone[k], 0);
    end
    tick();
    reset_n = 1;
    cnt = 0;
    while (a_wr[0] && cnt < 100) begin
      cnt++;
      for (int k = 0; k < 2; k++) vs = vs | a_rv[k] | b_rv[k];
      tick();
    end
    chk("clear_len2", cnt, 16);
    chk("stale_valid", vs, 0);
    rd(1, 4'd9, 32'h0, 32'h0, "reclr_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avmm_dp_onchip_ram.md
Name: avmm_dp_onchip_ram

Overview:
Parametrised true dual-port on-chip RAM with two independent Avalon-MM slave ports (s1 = port A, s2 = port B) on one clock. It is the next generation of the Qsys on-chip memory. It adds configurable width, depth and read latency, explicit read/readdatavalid/waitrequest handshakes, and an optional zero-fill sweep after reset. It also adds deterministic same-address collision handling with a collision flag. It sits on the Nios II data/instruction fabric and serves as a shared frame/sprite buffer between the CPU and the video engine.

Parameters:
DATA_W, 32, data width per port in bits; must be a multiple of 8.
ADDR_W, 16, word address width; DEPTH = 2**ADDR_W words.
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = no sweep, contents undefined.
COLLISION_MODE, 0, winner of a same-address, same-byte write-write collision: 0 = port A, 1 = port B.

Ports:
clk  in  1  single clock for everything.
reset_n  in  1  asynchronous active-low reset.
freeze  in  1  1 = block new accepts on both ports.
a_address / b_address  in  ADDR_W  word address.
a_chipselect / b_chipselect  in  1  port select.
a_read / b_read  in  1  read request.
a_write / b_write  in  1  write request.
a_byteenable / b_byteenable  in  DATA_W/8  byte lane enables.
a_writedata / b_writedata  in  DATA_W  write data.
a_clken / b_clken  in  1  per-port accept enable.
a_readdata / b_readdata  out  DATA_W  read data.
a_readdatavalid / b_readdatavalid  out  1  one-cycle pulse per accepted read.
a_waitrequest / b_waitrequest  out  1  1 = request not accepted this cycle.
init_done  out  1  1 = clear sweep finished, or CLEAR_ON_RESET=0.
collision  out  1  one-cycle pulse, one cycle after a write-write same-address collision.

Behaviour:
Reset (asynchronous on reset_n low):
- readdata = 0, readdatavalid = 0, collision = 0, all in-flight reads discarded.
- waitrequest = CLEAR_ON_RESET, init_done = !CLEAR_ON_RESET.
- State goes to CLEAR if CLEAR_ON_RESET=1, otherwise RUN.

FSM states: CLEAR, RUN.
- CLEAR: an ADDR_W-bit counter starts at 0 and writes all-zero words, all byte lanes, through port A, one word per cycle.
  - Both waitrequests are held at 1 throughout CLEAR.
  - The cycle that writes counter == DEPTH-1 is the last CLEAR cycle. The next cycle is RUN, with init_done = 1 and waitrequest = 0.
  - CLEAR lasts exactly DEPTH cycles after reset release.
- RUN: normal operation. There is no exit except reset. Reset mid-sweep restarts CLEAR from address 0.

Accept rule, per port: accept = chipselect & (read | write) & clken & ~waitrequest.
- In RUN, waitrequest = freeze. a_clken and b_clken do not drive waitrequest.
- If read and write are both asserted, the request is treated as a write only and no readdatavalid is produced.

Write:
- Only byte lanes with byteenable = 1 are updated, at the accepting edge.
- byteenable = 0 gives an accepted no-op write.

Read:
- RD_LATENCY=1: readdata and readdatavalid are registered on the edge after the accept.
- RD_LATENCY=2: a second output register adds one cycle.
- The pipeline always advances; clken and freeze never stall in-flight reads.
- readdata holds its last value when valid = 0.
- Back-to-back reads give back-to-back valids, throughput 1 per cycle per port.

Same-port read after write, consecutive cycles: the read returns the new data.

Mixed-port collisions, same cycle, equal addresses:
- Write + write:
  - Lanes enabled by only one port take that port's data.
  - Lanes enabled by both ports take the COLLISION_MODE winner's data. This is implemented by masking the loser's overlapping byteenables.
  - collision pulses 1 on the next cycle, whenever the write-write addresses are equal, even with no lane overlap.
- Write + read: the read returns the old (pre-write) data. No collision pulse.

Other boundary conditions:
- Address wraps naturally; there is no out-of-range address.
- freeze asserted mid-read: pending valids still emerge at their scheduled cycles.

Decomposition:
Shared package onchip_mem_pkg holds:
- the state typedef (CLEAR, RUN);
- COLL_A_WINS = 0 and COLL_B_WINS = 1;
- MAX_RD_LATENCY = 2.

Sub-module onchip_mem_rd_pipe is the per-port readdata/readdatavalid pipeline, parametrised by DATA_W and RD_LATENCY, and is instantiated twice. The RAM array, collision masking and clear FSM live in the top level.

Test Plan:
1. ADDR_W=4, CLEAR_ON_RESET=1; release reset_n → waitrequest=1 for exactly 16 cycles, then init_done=1; reads of addresses 0..15 all return 0x00000000.
2. Port A writes 0xDEADBEEF to address 5 with byteenable 4'b1111, then writes 0x000000AA with byteenable 4'b0001. Port B reads address 5 → readdata 0xDEADBEAA with valid exactly RD_LATENCY cycles after accept, run at RD_LATENCY 1 and 2.
3. Same cycle: A writes 0x11111111 with byteenable 4'b0011 and B writes 0x22222222 with byteenable 4'b0110 to address 9, COLLISION_MODE=0 → memory holds 0xXX221111 with the top byte unchanged (0x00), i.e. 0x00221111; collision pulses once.
4. Same cycle: A writes 0x12345678 to address 3 (previously 0xCAFEF00D) while B reads address 3 → B readdata 0xCAFEF00D; the next B read returns 0x12345678; collision stays 0.
5. 8 back-to-back reads on port A, freeze raised after the 4th accept → exactly 4 valid pulses; waitrequest=1 while frozen; after freeze drops, the remaining 4 reads complete in order.
6. Assert reset_n low mid-CLEAR at counter 7, with a read in flight in RUN in a second run → outputs zero immediately; CLEAR restarts at 0; no stale readdatavalid after release.
